// File: rtl/muldiv_seq.sv
// muldiv_seq: 32x32 sequential multiply/divide (radix-2 shift-add / restoring), 35-cycle latency, 2 for divide-by-zero.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier magnitude is zero.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  func,
    input  logic [31:0] op_0,
    input  logic [31:0] op_1,
    input  logic        flush,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic        r_is_div, r_is_signed;
    logic [31:0] r_op0, r_op1;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc, r_mcand;
    logic [31:0] r_mplier;
    logic        r_neg_lo, r_neg_hi, r_div0;
    logic [31:0] r_hi, r_lo;

    logic        w_func_ok, w_accept, w_div_zero, w_early;
    logic [31:0] w_mag0, w_mag1, w_quo, w_rem;
    logic [32:0] w_trial;
    logic [63:0] w_prod;

    assign w_func_ok  = (func[5:2] == 4'b0001);
    assign w_accept   = start && !flush && w_func_ok;
    assign w_mag0     = (r_is_signed && r_op0[31]) ? -r_op0 : r_op0;
    assign w_mag1     = (r_is_signed && r_op1[31]) ? -r_op1 : r_op1;
    assign w_div_zero = r_is_div && (r_op1 == 32'd0);
    // For divide r_acc holds {remainder, dividend-shifting-into-quotient}.
    assign w_trial    = r_acc[63:31] - {1'b0, r_mplier};
    assign w_prod     = r_neg_lo ? -r_acc : r_acc;
    assign w_quo      = r_neg_lo ? -r_acc[31:0] : r_acc[31:0];
    assign w_rem      = r_neg_hi ? -r_acc[63:32] : r_acc[63:32];

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = !r_is_div && (r_mplier[31:1] == 31'd0);
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_PREP;
            S_PREP: w_state_nxt = w_div_zero ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == 5'd0 || w_early) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush && r_state != S_IDLE) w_state_nxt = S_IDLE;
    end

    always_comb begin
        ready = (r_state == S_IDLE);
        busy  = (r_state != S_IDLE);
        done  = (r_state == S_DONE);
        div0  = (r_state == S_DONE) && r_div0;
    end

    assign hi = r_hi;
    assign lo = r_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_div    <= 1'b0;
            r_is_signed <= 1'b0;
            r_op0       <= '0;
            r_op1       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_neg_lo    <= 1'b0;
            r_neg_hi    <= 1'b0;
            r_div0      <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_is_div    <= func[1];
                    r_is_signed <= !func[0];
                    r_op0       <= op_0;
                    r_op1       <= op_1;
                end
                S_PREP: begin
                    r_cnt    <= 5'd31;
                    r_div0   <= w_div_zero;
                    r_neg_lo <= r_is_signed && (r_op0[31] ^ r_op1[31]);
                    r_neg_hi <= r_is_signed && r_op0[31];
                    r_mplier <= w_mag1;
                    r_mcand  <= {32'd0, w_mag0};
                    r_acc    <= r_is_div ? {32'd0, w_mag0} : 64'd0;
                    if (w_div_zero && !flush) begin
                        r_hi <= r_op0;
                        r_lo <= 32'hFFFF_FFFF;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (r_is_div) begin
                        if (!w_trial[32]) r_acc <= {w_trial[31:0], r_acc[30:0], 1'b1};
                        else              r_acc <= {r_acc[62:0], 1'b0};
                    end else begin
                        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end
                end
                S_FIX: if (!flush) begin
                    r_hi <= r_is_div ? w_rem : w_prod[63:32];
                    r_lo <= r_is_div ? w_quo : w_prod[31:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, randomized ops vs. arithmetic model, flush/reset/busy corner sequences.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [5:0]  func;
    logic [31:0] op_0, op_1;
    logic        ready, busy, done, div0;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .op_0(op_0), .op_1(op_1),
        .flush(flush), .ready(ready), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a, b, exp_hi, exp_lo;
        logic        exp_div0;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int lat_of(input logic [5:0] f, input logic [31:0] b);
        if (f[1] && b == 32'd0) return 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f[1]) begin
            logic [31:0] m;
            int bits;
            m = (!f[0] && b[31]) ? -b : b;
            bits = 1;
            for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
            return bits + 3;
        end
`endif
        return 35;
    endfunction

    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ed0);
        logic [63:0] p;
        int sa, sb;
        ed0 = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            6'h4: begin p = longint'(sa) * longint'(sb); eh = p[63:32]; el = p[31:0]; end
            6'h5: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    eh = a; el = 32'hFFFF_FFFF; ed0 = 1'b1;
                end else if (f == 6'h7) begin
                    el = a / b; eh = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = 32'd0;
                end else begin
                    el = sa / sb; eh = sa % sb;
                end
            end
        endcase
    endfunction

    task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
        start = 1'b1; func = f; op_0 = a; op_1 = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called at cycle c0 (1 = the cycle right after the acceptance edge), sampled #1 after the edge.
    task automatic wait_done(input int c0, output logic [31:0] gh, output logic [31:0] gl,
                             output logic gd0, output int lat, output int busy_bad);
        lat = -1; busy_bad = 0; gh = '0; gl = '0; gd0 = 1'b0;
        for (int c = c0; c <= 60; c++) begin
            if (!busy) busy_bad++;
            if (done) begin
                lat = c; gh = hi; gl = lo; gd0 = div0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eh, input logic [31:0] el, input logic ed0);
        logic [31:0] gh, gl;
        logic gd0;
        int lat, bb;
        launch(f, a, b);
        wait_done(1, gh, gl, gd0, lat, bb);
        check({tag, " hi"}, 64'(gh), 64'(eh));
        check({tag, " lo"}, 64'(gl), 64'(el));
        check({tag, " div0"}, 64'(gd0), 64'(ed0));
        check({tag, " latency"}, 64'(lat), 64'(lat_of(f, b)));
        check({tag, " busy"}, 64'(bb), 64'd0);
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        logic [31:0] gh, gl, eh, el, a, b;
        logic gd0, ed0;
        logic [5:0] f;
        int lat, bb, cnt;

        vecs[0]  = '{6'h4, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{6'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2]  = '{6'h6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{6'h6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4]  = '{6'h7, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{6'h7, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0};
        vecs[6]  = '{6'h6, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[7]  = '{6'h5, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b0};
        vecs[8]  = '{6'h6, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{6'h4, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
        vecs[10] = '{6'h4, 32'h1234_5678, 32'd0,        32'd0,         32'd0,         1'b0};
        vecs[11] = '{6'h7, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 1'b0};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; func = '0; op_0 = '0; op_1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        check("reset ready", 64'(ready), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div0", 64'(div0), 64'd0);
        check("reset hi/lo", {hi, lo}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                          vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_div0);
            @(posedge clk); #1;
            check($sformatf("vec%0d done pulse", i), {63'd0, done}, 64'd0);
            check($sformatf("vec%0d back idle", i), {63'd0, ready}, 64'd1);
        end

        for (int i = 0; i < 40; i++) begin
            f = 6'h4 + 6'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
                3: b = 32'($urandom_range(0, 255));
                default: ;
            endcase
            model(f, a, b, eh, el, ed0);
            run_and_check($sformatf("rnd%0d f=%0h a=%h b=%h", i, f, a, b), f, a, b, eh, el, ed0);
        end

        // Illegal func code is ignored.
        @(negedge clk); start = 1'b1; func = 6'h0C; op_0 = 32'd3; op_1 = 32'd4;
        @(posedge clk); #1; start = 1'b0;
        check("bad func stays idle", {63'd0, ready}, 64'd1);

        // flush together with start in IDLE: not accepted.
        @(negedge clk); start = 1'b1; flush = 1'b1; func = 6'h5;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        check("flush+start stays idle", {63'd0, busy}, 64'd0);

        // Start pulsed while busy must not recapture operands.
        launch(6'h7, 32'd1000, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; func = 6'h5; op_0 = 32'd3; op_1 = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        wait_done(6, gh, gl, gd0, lat, bb);
        check("busy start hi", 64'(gh), 64'd6);
        check("busy start lo", 64'(gl), 64'd142);
        check("busy start latency", 64'(lat), 64'd35);
        @(posedge clk); #1;
        check("busy start no relaunch", {63'd0, busy}, 64'd0);

        // Flush during cycle 10 of a divide.
        launch(6'h7, 32'h0000_FFFF, 32'd3);
        cnt = 0;
        repeat (9) begin @(posedge clk); #1; if (done) cnt++; end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush idle at 11", {63'd0, ready}, 64'd1);
        check("flush hi/lo held", {hi, lo}, {32'd6, 32'd142});
        count_done(45, lat);
        check("flush no done", 64'(cnt + lat), 64'd0);
        check("flush hi/lo still held", {hi, lo}, {32'd6, 32'd142});

        // Flush during DONE: pulse and committed result survive.
        launch(6'h6, 32'hFFFF_FF9C, 32'd7);
        wait_done(1, gh, gl, gd0, lat, bb);
        flush = 1'b1; #1;
        check("flush in done pulse", {63'd0, done}, 64'd1);
        check("flush in done result", {hi, lo}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        @(posedge clk); #1; flush = 1'b0;
        check("flush in done idle", {63'd0, ready}, 64'd1);
        check("flush in done held", {hi, lo}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

        // Reset mid-operation.
        launch(6'h5, 32'h1234, 32'h5678);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        check("mid reset ready", {63'd0, ready}, 64'd1);
        check("mid reset hi/lo", {hi, lo}, 64'd0);
        count_done(45, cnt);
        check("mid reset no done", 64'(cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
